// File: rtl/ysyx_22040759_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_22040759_ifu -- instruction fetch unit
//
// Holds the PC, issues one instruction-memory request at a time and presents
// the returned word, with its PC, to decode through a valid/ready handshake.
// A jump redirect from the jal/jalr path reloads the PC in any state. A fetch
// that is already in flight when the redirect arrives is marked stale, and its
// response is thrown away.
//
// Ports
//   clk, rst         clock (rising edge), synchronous active-high reset
//   imem_req_*       fetch request: valid/ready handshake, address = pc
//   imem_rsp_*       fetch response: valid plus 32-bit instruction word
//   redirect_*       jump taken; new PC target
//   inst_*           registered instruction and its PC, valid/ready to decode
//   fetch_misalign   sticky misaligned-redirect flag
//
// Configuration macro: IFU_MISALIGN_CHK_EN
//   defined   : a redirect whose target has nonzero low bits sets fetch_misalign
//               and parks the unit in IDLE until reset
//   undefined : fetch_misalign is tied to 0 and the low two bits of the target
//               are cleared when it is loaded
// ---------------------------------------------------------------------------
module ysyx_22040759_ifu #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            latch;
  logic [XLEN-1:0] redirect_load;
  logic            mis_q, mis_d;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] inst_pc_q;

`ifdef IFU_MISALIGN_CHK_EN
  logic redirect_bad;
  assign redirect_bad  = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redirect_load = redirect_pc;
`else
  logic unused_redirect_lo;
  assign unused_redirect_lo = ^redirect_pc[1:0];
  assign redirect_load      = {redirect_pc[XLEN-1:2], 2'b00};
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    mis_d   = mis_q;
    latch   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A latched misalignment parks the unit here until reset.
        if (!mis_q) state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
          // The accepted request carries the old address and is now stale.
          if (redirect_valid) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (drop_q || redirect_valid) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            latch   = 1'b1;
            state_d = S_HOLD;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        // A handshake that coincides with a redirect still consumes the
        // instruction; only the PC source differs.
        if (redirect_valid)  state_d = S_REQ;
        else if (inst_ready) begin
          state_d = S_REQ;
          pc_d    = pc_q + XLEN'(4);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) begin
      pc_d = redirect_load;
`ifdef IFU_MISALIGN_CHK_EN
      if (redirect_bad) begin
        mis_d   = 1'b1;
        state_d = S_IDLE;
        drop_d  = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      drop_q    <= 1'b0;
      mis_q     <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      mis_q   <= mis_d;
      if (latch) begin
        inst_q    <= imem_rsp_data;
        inst_pc_q <= pc_q;
      end
    end
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == S_HOLD);
  assign inst_o         = inst_q;
  assign inst_pc        = inst_pc_q;
`ifdef IFU_MISALIGN_CHK_EN
  assign fetch_misalign = mis_q;
`else
  assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22040759_ifu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22040759_ifu -- directed bench for the instruction fetch unit
// (default build, misalignment check disabled). Each step drives one cycle of
// inputs, clocks once and compares every output against hand-computed values.
// ---------------------------------------------------------------------------
module tb_ysyx_22040759_ifu;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_o;
  logic [63:0] inst_pc;
  logic        fetch_misalign;

  ysyx_22040759_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_o         (inst_o),
    .inst_pc        (inst_pc),
    .fetch_misalign (fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        redir;
    logic [63:0] rpc;
    logic        ir;
    logic        e_rv;
    logic [63:0] e_addr;
    logic        e_iv;
    logic [31:0] e_io;
    logic [63:0] e_ipc;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic vec_t mk(logic r, logic rdy, logic rv, logic [31:0] rd,
                              logic redir, logic [63:0] rpc, logic ir,
                              logic e_rv, logic [63:0] e_addr, logic e_iv,
                              logic [31:0] e_io, logic [63:0] e_ipc);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rv = rv; v.rd = rd; v.redir = redir; v.rpc = rpc;
    v.ir = ir; v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv;
    v.e_io = e_io; v.e_ipc = e_ipc;
    return v;
  endfunction

  task automatic step(input vec_t v, input string nm);
    rst            = v.rst;
    imem_req_ready = v.rdy;
    imem_rsp_valid = v.rv;
    imem_rsp_data  = v.rd;
    redirect_valid = v.redir;
    redirect_pc    = v.rpc;
    inst_ready     = v.ir;
    @(posedge clk);
    #1;
    n_checks++;
    if (imem_req_valid === v.e_rv && imem_req_addr === v.e_addr &&
        inst_valid === v.e_iv && inst_o === v.e_io && inst_pc === v.e_ipc &&
        fetch_misalign === 1'b0) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got req_v=%b addr=%h inst_v=%b inst=%h ipc=%h mis=%b; want req_v=%b addr=%h inst_v=%b inst=%h ipc=%h mis=0",
               nm, imem_req_valid, imem_req_addr, inst_valid, inst_o, inst_pc,
               fetch_misalign, v.e_rv, v.e_addr, v.e_iv, v.e_io, v.e_ipc);
    end
  endtask

  localparam logic [63:0] P0 = 64'h8000_0000;

  vec_t tbl[21];

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    imem_rsp_data = '0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

    // Reset, first fetch, two more streamed fetches, 5-cycle decode stall,
    // then a request held off by ready=0 and a 2-cycle memory latency.
    //              rst rdy rv data           rdr rpc ir  e_rv e_addr     e_iv e_io           e_ipc
    tbl[0]  = mk(1, 0, 0, 32'h0,        0, 0, 0,  0, P0,        0, 32'h0,        64'h0);
    tbl[1]  = mk(0, 0, 0, 32'h0,        0, 0, 1,  1, P0,        0, 32'h0,        64'h0);
    tbl[2]  = mk(0, 1, 0, 32'h0,        0, 0, 1,  0, P0,        0, 32'h0,        64'h0);
    tbl[3]  = mk(0, 0, 1, 32'h00000513, 0, 0, 1,  0, P0,        1, 32'h00000513, P0);
    tbl[4]  = mk(0, 0, 0, 32'h0,        0, 0, 1,  1, P0 + 4,    0, 32'h00000513, P0);
    tbl[5]  = mk(0, 1, 0, 32'h0,        0, 0, 1,  0, P0 + 4,    0, 32'h00000513, P0);
    tbl[6]  = mk(0, 0, 1, 32'h00100093, 0, 0, 1,  0, P0 + 4,    1, 32'h00100093, P0 + 4);
    tbl[7]  = mk(0, 0, 0, 32'h0,        0, 0, 1,  1, P0 + 8,    0, 32'h00100093, P0 + 4);
    tbl[8]  = mk(0, 1, 0, 32'h0,        0, 0, 0,  0, P0 + 8,    0, 32'h00100093, P0 + 4);
    tbl[9]  = mk(0, 0, 1, 32'h00200113, 0, 0, 0,  0, P0 + 8,    1, 32'h00200113, P0 + 8);
    tbl[10] = mk(0, 1, 0, 32'h0,        0, 0, 0,  0, P0 + 8,    1, 32'h00200113, P0 + 8);
    tbl[11] = mk(0, 1, 1, 32'hBAD0BAD0, 0, 0, 0,  0, P0 + 8,    1, 32'h00200113, P0 + 8);
    tbl[12] = mk(0, 0, 0, 32'h0,        0, 0, 0,  0, P0 + 8,    1, 32'h00200113, P0 + 8);
    tbl[13] = mk(0, 0, 1, 32'h12345678, 0, 0, 0,  0, P0 + 8,    1, 32'h00200113, P0 + 8);
    tbl[14] = mk(0, 0, 0, 32'h0,        0, 0, 0,  0, P0 + 8,    1, 32'h00200113, P0 + 8);
    tbl[15] = mk(0, 0, 0, 32'h0,        0, 0, 1,  1, P0 + 12,   0, 32'h00200113, P0 + 8);
    tbl[16] = mk(0, 0, 0, 32'h0,        0, 0, 1,  1, P0 + 12,   0, 32'h00200113, P0 + 8);
    tbl[17] = mk(0, 1, 0, 32'h0,        0, 0, 1,  0, P0 + 12,   0, 32'h00200113, P0 + 8);
    tbl[18] = mk(0, 0, 0, 32'h0,        0, 0, 1,  0, P0 + 12,   0, 32'h00200113, P0 + 8);
    tbl[19] = mk(0, 0, 1, 32'h00300193, 0, 0, 0,  0, P0 + 12,   1, 32'h00300193, P0 + 12);
    tbl[20] = mk(0, 0, 0, 32'h0,        0, 0, 1,  1, P0 + 16,   0, 32'h00300193, P0 + 12);

    for (int i = 0; i < 21; i++) step(tbl[i], $sformatf("table[%0d]", i));

    // Redirect while waiting; the old response must be discarded.
    step(mk(0, 1, 0, 32'h0,        0, 0,                0, 0, P0 + 16,           0, 32'h00300193, P0 + 12), "wait_accept");
    step(mk(0, 0, 0, 32'h0,        1, 64'h8000_0100,    0, 0, 64'h8000_0100,     0, 32'h00300193, P0 + 12), "wait_redirect");
    step(mk(0, 0, 1, 32'hDEADBEEF, 0, 0,                0, 1, 64'h8000_0100,     0, 32'h00300193, P0 + 12), "stale_rsp_dropped");
    step(mk(0, 1, 0, 32'h0,        0, 0,                0, 0, 64'h8000_0100,     0, 32'h00300193, P0 + 12), "redir_accept");
    step(mk(0, 0, 1, 32'h00000013, 0, 0,                0, 0, 64'h8000_0100,     1, 32'h00000013, 64'h8000_0100), "redir_inst");

    // Redirect in HOLD together with a consume: pc takes the target.
    step(mk(0, 0, 0, 32'h0,        1, 64'h8000_0200,    1, 1, 64'h8000_0200,     0, 32'h00000013, 64'h8000_0100), "hold_redirect_ready");

    // Redirect in REQ, first not accepted, then accepted the same cycle.
    step(mk(0, 0, 0, 32'h0,        1, 64'h8000_0280,    0, 1, 64'h8000_0280,     0, 32'h00000013, 64'h8000_0100), "req_redirect_noacc");
    step(mk(0, 1, 0, 32'h0,        1, 64'h8000_0300,    0, 0, 64'h8000_0300,     0, 32'h00000013, 64'h8000_0100), "req_redirect_acc");
    step(mk(0, 0, 1, 32'h11111111, 0, 0,                0, 1, 64'h8000_0300,     0, 32'h00000013, 64'h8000_0100), "req_acc_rsp_dropped");

    // Redirect coinciding with the response in WAIT.
    step(mk(0, 1, 0, 32'h0,        0, 0,                0, 0, 64'h8000_0300,     0, 32'h00000013, 64'h8000_0100), "accept_0300");
    step(mk(0, 0, 1, 32'h22222222, 1, 64'h8000_0400,    0, 1, 64'h8000_0400,     0, 32'h00000013, 64'h8000_0100), "wait_redirect_rsp");

    // Misaligned target: low bits cleared, fetch at 8000_0100.
    step(mk(0, 0, 0, 32'h0,        1, 64'h8000_0102,    0, 1, 64'h8000_0100,     0, 32'h00000013, 64'h8000_0100), "misalign_cleared");
    step(mk(0, 1, 0, 32'h0,        0, 0,                0, 0, 64'h8000_0100,     0, 32'h00000013, 64'h8000_0100), "misalign_accept");
    step(mk(0, 0, 1, 32'h00000073, 0, 0,                0, 0, 64'h8000_0100,     1, 32'h00000073, 64'h8000_0100), "misalign_inst");

    // PC wrap from the top of the address space.
    step(mk(0, 0, 0, 32'h0,        1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h00000073, 64'h8000_0100), "hold_redirect_top");
    step(mk(0, 1, 0, 32'h0,        0, 0,                0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h00000073, 64'h8000_0100), "top_accept");
    step(mk(0, 0, 1, 32'h0000006F, 0, 0,                0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 32'h0000006F, 64'hFFFF_FFFF_FFFF_FFFC), "top_inst");
    step(mk(0, 0, 0, 32'h0,        0, 0,                1, 1, 64'h0,             0, 32'h0000006F, 64'hFFFF_FFFF_FFFF_FFFC), "pc_wrap");

    // Reset with a request in flight; the late response is ignored and a
    // redirect in IDLE goes straight to REQ at the target.
    step(mk(0, 1, 0, 32'h0,        0, 0,                0, 0, 64'h0,             0, 32'h0000006F, 64'hFFFF_FFFF_FFFF_FFFC), "inflight_accept");
    step(mk(1, 0, 0, 32'h0,        0, 0,                0, 0, P0,                0, 32'h0,        64'h0), "mid_reset");
    step(mk(0, 0, 1, 32'hCAFEF00D, 1, 64'h8000_0500,    0, 1, 64'h8000_0500,     0, 32'h0,        64'h0), "idle_redirect_late_rsp");
    step(mk(0, 1, 0, 32'h0,        0, 0,                0, 0, 64'h8000_0500,     0, 32'h0,        64'h0), "post_reset_accept");
    step(mk(0, 0, 1, 32'h00500513, 0, 0,                0, 0, 64'h8000_0500,     1, 32'h00500513, 64'h8000_0500), "post_reset_inst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
